// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer.
// State encoding is fixed so it can be observed in waveforms or debug taps.
package piso_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        PARITY = ST_PARITY
    } state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and shift enable.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int MSB = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [MSB-1:0] data_in,
    input  logic           valid_in,
    output logic           ready_out,
    input  logic           dir,
    input  logic           ena,
    output logic           q,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(MSB);

    state_t         state, state_n;
    logic [MSB-1:0] shreg, shreg_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           dir_q, dir_n;
    logic           done_n;
    logic           last;
    logic           accept;
`ifdef PISO_PARITY_EN
    logic           par_q, par_n;
`endif

    assign last   = (state == SHIFT) && (cnt == CW'(MSB - 1));
    assign busy   = (state != IDLE);
    assign accept = valid_in && ready_out;

`ifdef PISO_PARITY_EN
    assign ready_out = (state == IDLE);
`else
    // Accepting on the final enabled bit makes frames abut with no gap.
    assign ready_out = (state == IDLE) || (last && ena);
`endif

    always_comb begin
        q = 1'b0;
        unique case (1'b1)
            (state == SHIFT):
                q = (dir_q == DIR_LSB_FIRST) ? shreg[0] : shreg[MSB-1];
`ifdef PISO_PARITY_EN
            (state == PARITY):
                q = par_q;
`endif
            default: q = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        dir_n   = dir_q;
        done_n  = 1'b0;
`ifdef PISO_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            SHIFT: begin
                if (ena) begin
                    if (dir_q == DIR_LSB_FIRST)
                        shreg_n = shreg >> 1;
                    else
                        shreg_n = shreg << 1;
                    cnt_n = cnt + CW'(1);
                    if (last) begin
                        cnt_n = '0;
`ifdef PISO_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = IDLE;
                        done_n  = 1'b1;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef PISO_PARITY_EN
                if (ena) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
`else
                state_n = IDLE;
`endif
            end
            default: ;
        endcase
        if (accept) begin
            shreg_n = data_in;
            dir_n   = dir;
            cnt_n   = '0;
            state_n = SHIFT;
`ifdef PISO_PARITY_EN
            par_n   = ^data_in;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            dir_q <= DIR_MSB_FIRST;
            done  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
            dir_q <= dir_n;
            done  <= done_n;
`ifdef PISO_PARITY_EN
            par_q <= par_n;
`endif
        end
    end

endmodule
